// File: rtl/common.sv
`default_nettype none
// ============================================================================
//  Module      : common_pkg
//  Description : Pixel format shared by the draw layers, the per-layer
//                frame storage and the compositor.
//                  COLOR_WIDTH - bits per stored pixel
//                  COLOR_NONE  - "no pixel here" (transparent) value; the
//                                frame clear fills storage with it
//  Revision    : 1.0 - initial release
// ============================================================================
package common_pkg;

    localparam int                     COLOR_WIDTH = 8;
    localparam logic [COLOR_WIDTH-1:0] COLOR_NONE  = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/framebuffer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : framebuffer_arbiter
//  Description : Shares one single-port pixel RAM (registered read, 1-cycle
//                latency) between the display scan-out reader, a full-frame
//                clear engine and NUM_WRITERS round-robin draw engines.
//                One RAM operation per cycle: scan read > clear > draw write.
//
//  Ports
//    clk, reset          clock, synchronous active-high reset
//    scan_req/x/y        scan-out pixel request (read issued this cycle)
//    scan_valid/data     scan result, one cycle after scan_req
//    wr_req/x/y/color    per-writer draw request, held until granted
//    wr_grant            one-hot, combinational; write accepted this cycle
//    clear_start         pulse; start filling the frame with COLOR_NONE
//    clear_busy          clear in progress
//    mem_addr/we/wdata   RAM command
//    mem_rdata           RAM read data, valid one cycle after the address
//
//  Revision    : 1.0 - initial release
// ============================================================================
module framebuffer_arbiter
    import common_pkg::*;
#(
    parameter  int WIDTH       = 640,
    parameter  int HEIGHT      = 480,
    parameter  int NUM_WRITERS = 4,
    localparam int XW          = $clog2(WIDTH),
    localparam int YW          = $clog2(HEIGHT),
    localparam int AW          = $clog2(WIDTH*HEIGHT)
) (
    input  logic                                  clk,
    input  logic                                  reset,

    input  logic                                  scan_req,
    input  logic [XW-1:0]                         scan_x,
    input  logic [YW-1:0]                         scan_y,
    output logic                                  scan_valid,
    output logic [COLOR_WIDTH-1:0]                scan_data,

    input  logic [NUM_WRITERS-1:0]                wr_req,
    input  logic [NUM_WRITERS-1:0][XW-1:0]        wr_x,
    input  logic [NUM_WRITERS-1:0][YW-1:0]        wr_y,
    input  logic [NUM_WRITERS-1:0][COLOR_WIDTH-1:0] wr_color,
    output logic [NUM_WRITERS-1:0]                wr_grant,

    input  logic                                  clear_start,
    output logic                                  clear_busy,

    output logic [AW-1:0]                         mem_addr,
    output logic                                  mem_we,
    output logic [COLOR_WIDTH-1:0]                mem_wdata,
    input  logic [COLOR_WIDTH-1:0]                mem_rdata
);

    localparam int            PW         = (NUM_WRITERS > 1) ? $clog2(NUM_WRITERS) : 1;
    localparam logic [AW-1:0] c_LAST_PIX = AW'(WIDTH*HEIGHT - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [AW-1:0]  r_clr_cnt;
    logic [AW-1:0]  w_clr_cnt_next;
    logic [PW-1:0]  r_ptr;
    logic [PW-1:0]  w_ptr_next;
    logic           r_scan_valid;
    logic           r_scan_oob;

    logic           w_found;
    int             w_win;
    logic           w_scan_ok;
    logic [AW-1:0]  w_scan_addr;

    // Linear pixel address, widened to the full address width before the
    // multiply so the product is never truncated to the coordinate width.
    function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] x,
                                               input logic [YW-1:0] y);
        return AW'(y) * AW'(WIDTH) + AW'(x);
    endfunction

    function automatic logic in_frame(input logic [XW-1:0] x,
                                      input logic [YW-1:0] y);
        return (32'(x) < WIDTH) && (32'(y) < HEIGHT);
    endfunction

    assign w_scan_ok   = in_frame(scan_x, scan_y);
    assign w_scan_addr = pix_addr(scan_x, scan_y);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_clr_cnt    <= '0;
            r_ptr        <= '0;
            r_scan_valid <= 1'b0;
            r_scan_oob   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_clr_cnt    <= w_clr_cnt_next;
            r_ptr        <= w_ptr_next;
            r_scan_valid <= scan_req;
            r_scan_oob   <= scan_req && !w_scan_ok;
        end
    end

    // ------------------------------------------------------------------
    // Next state, RAM command and writer grant
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_ptr_next     = r_ptr;
        wr_grant       = '0;
        mem_addr       = '0;
        mem_we         = 1'b0;
        mem_wdata      = '0;
        w_found        = 1'b0;
        w_win          = 0;

        // A clear can be launched even in a cycle the scan owns the RAM;
        // it simply begins writing once the port is free.
        if (r_state == S_IDLE && clear_start) begin
            w_state_next   = S_CLEAR;
            w_clr_cnt_next = '0;
        end

        if (scan_req) begin
            // Out-of-frame scans never touch the RAM; the result is
            // substituted on the return path instead.
            if (w_scan_ok) begin
                mem_addr = w_scan_addr;
            end
        end else if (r_state == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = r_clr_cnt;
            mem_wdata = COLOR_NONE;
            if (r_clr_cnt == c_LAST_PIX) begin
                w_state_next   = S_IDLE;
                w_clr_cnt_next = '0;
            end else begin
                w_clr_cnt_next = r_clr_cnt + AW'(1);
            end
        end else if (!clear_start) begin
            // Round-robin search starting at the priority pointer.
            for (int k = 0; k < NUM_WRITERS; k++) begin
                if (!w_found && wr_req[(int'(r_ptr) + k) % NUM_WRITERS]) begin
                    w_found = 1'b1;
                    w_win   = (int'(r_ptr) + k) % NUM_WRITERS;
                end
            end
            if (w_found) begin
                wr_grant[w_win] = 1'b1;
                w_ptr_next      = PW'((w_win + 1) % NUM_WRITERS);
                // Off-frame draws are granted so the writer moves on, but
                // nothing is written.
                if (in_frame(wr_x[w_win], wr_y[w_win])) begin
                    mem_we    = 1'b1;
                    mem_addr  = pix_addr(wr_x[w_win], wr_y[w_win]);
                    mem_wdata = wr_color[w_win];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign clear_busy = (r_state == S_CLEAR);
    assign scan_valid = r_scan_valid;
    // mem_rdata is itself registered by the RAM, so this is aligned with
    // scan_valid without another pipeline stage.
    assign scan_data  = !r_scan_valid ? '0 :
                        r_scan_oob    ? COLOR_NONE : mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_framebuffer_arbiter
//  Description : Self-checking bench for framebuffer_arbiter on a 4x3 frame
//                with four writers. Directed steps cover reset, scan latency,
//                round-robin order, priorities, clear stall/abort and
//                off-frame accesses; a randomized phase compares grants and
//                scan results with a picture/pointer reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_framebuffer_arbiter;
    import common_pkg::*;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = 4;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam int AW = $clog2(W*H);
    localparam int CW = COLOR_WIDTH;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       scan_req;
    logic [XW-1:0]              scan_x;
    logic [YW-1:0]              scan_y;
    logic                       scan_valid;
    logic [CW-1:0]              scan_data;
    logic [N-1:0]               wr_req;
    logic [N-1:0][XW-1:0]       wr_x;
    logic [N-1:0][YW-1:0]       wr_y;
    logic [N-1:0][CW-1:0]       wr_color;
    logic [N-1:0]               wr_grant;
    logic                       clear_start;
    logic                       clear_busy;
    logic [AW-1:0]              mem_addr;
    logic                       mem_we;
    logic [CW-1:0]              mem_wdata;
    logic [CW-1:0]              mem_rdata;

    framebuffer_arbiter #(
        .WIDTH       (W),
        .HEIGHT      (H),
        .NUM_WRITERS (N)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .scan_req    (scan_req),
        .scan_x      (scan_x),
        .scan_y      (scan_y),
        .scan_valid  (scan_valid),
        .scan_data   (scan_data),
        .wr_req      (wr_req),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_color    (wr_color),
        .wr_grant    (wr_grant),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered read, plus a backdoor preload port.
    logic [CW-1:0] ram [0:15];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [CW-1:0] bd_data;

    always @(posedge clk) begin
        if (bd_we)       ram[bd_addr]  <= bd_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference model state
    int            exp_mem [0:W*H-1];
    int            ptr_m;
    int            cnt;
    int            j;
    int            win;
    logic [31:0]   exp_grant;
    logic          exp_we;
    logic          prev_scan;
    int            prev_exp;

    initial begin
        reset       = 1'b1;
        scan_req    = 1'b0;
        scan_x      = '0;
        scan_y      = '0;
        wr_req      = '0;
        wr_x        = '0;
        wr_y        = '0;
        wr_color    = '0;
        clear_start = 1'b0;
        bd_we       = 1'b0;
        bd_addr     = '0;
        bd_data     = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_scan_valid", 32'(scan_valid), 0);
        chk("rst_scan_data",  32'(scan_data),  0);
        chk("rst_clear_busy", 32'(clear_busy), 0);
        chk("rst_wr_grant",   32'(wr_grant),   0);
        chk("rst_mem_we",     32'(mem_we),     0);
        reset = 1'b0;

        // Preload pixel (2,1) = address 6 with 5
        bd_we = 1'b1; bd_addr = AW'(6); bd_data = CW'(5);
        tick();
        bd_we = 1'b0;

        // ---------------- scan read latency ----------------
        scan_req = 1'b1; scan_x = XW'(2); scan_y = YW'(1);
        #1;
        chk("scan_addr", 32'(mem_addr), 6);
        chk("scan_we",   32'(mem_we),   0);
        tick();
        scan_req = 1'b0;
        #1;
        chk("scan_valid", 32'(scan_valid), 1);
        chk("scan_data",  32'(scan_data),  5);
        tick();

        // ---------------- round robin ----------------
        for (int i = 0; i < N; i++) begin
            wr_x[i]     = XW'(i);
            wr_y[i]     = '0;
            wr_color[i] = CW'(10 + i);
        end
        wr_req = 4'b1111;
        for (int k = 0; k < N; k++) begin
            #1;
            chk("rr_grant", 32'(wr_grant),  32'(1) << k);
            chk("rr_we",    32'(mem_we),    1);
            chk("rr_addr",  32'(mem_addr),  32'(k));
            chk("rr_wdata", 32'(mem_wdata), 32'(10 + k));
            tick();
        end
        wr_req = 4'b1001;
        #1;
        chk("rr_wrap_grant", 32'(wr_grant), 1);
        tick();
        wr_req = '0;

        // ---------------- scan beats writer ----------------
        wr_req = 4'b0100; wr_x[2] = XW'(3); wr_y[2] = YW'(2); wr_color[2] = CW'(7);
        scan_req = 1'b1; scan_x = XW'(1); scan_y = YW'(2);
        #1;
        chk("prio_grant", 32'(wr_grant), 0);
        chk("prio_we",    32'(mem_we),   0);
        chk("prio_addr",  32'(mem_addr), 9);
        tick();
        scan_req = 1'b0;
        #1;
        chk("prio_grant2",    32'(wr_grant),   32'b0100);
        chk("prio_addr2",     32'(mem_addr),   11);
        chk("prio_wdata2",    32'(mem_wdata),  7);
        chk("prio_we2",       32'(mem_we),     1);
        chk("prio_scanvalid", 32'(scan_valid), 1);
        tick();
        wr_req = '0;

        // ---------------- off-frame accesses ----------------
        // x=4 does not fit a 2-bit column, so the off-frame writer uses y=3.
        wr_req = 4'b0010; wr_x[1] = XW'(1); wr_y[1] = YW'(3);
        #1;
        chk("oob_wr_grant", 32'(wr_grant), 32'b0010);
        chk("oob_wr_we",    32'(mem_we),   0);
        tick();
        wr_req = '0;
        scan_req = 1'b1; scan_x = XW'(0); scan_y = YW'(3);
        #1;
        chk("oob_scan_we", 32'(mem_we), 0);
        tick();
        scan_req = 1'b0;
        #1;
        chk("oob_scan_valid", 32'(scan_valid), 1);
        chk("oob_scan_data",  32'(scan_data),  32'(COLOR_NONE));
        tick();

        // ---------------- full clear with one stall ----------------
        wr_req = 4'b0001; wr_x[0] = '0; wr_y[0] = '0; wr_color[0] = CW'(9);
        clear_start = 1'b1;
        #1;
        chk("clr_start_grant", 32'(wr_grant),   0);
        chk("clr_start_busy",  32'(clear_busy), 0);
        tick();
        clear_start = 1'b0;
        cnt = 0;
        for (int c = 0; c < W*H + 1; c++) begin
            scan_req    = (c == 5);
            scan_x      = '0;
            scan_y      = '0;
            clear_start = (c == 8);
            #1;
            chk("clr_busy",  32'(clear_busy), 1);
            chk("clr_grant", 32'(wr_grant),   0);
            if (scan_req) begin
                chk("clr_stall_we", 32'(mem_we), 0);
            end else begin
                chk("clr_we",    32'(mem_we),    1);
                chk("clr_addr",  32'(mem_addr),  32'(cnt));
                chk("clr_wdata", 32'(mem_wdata), 32'(COLOR_NONE));
                cnt++;
            end
            tick();
        end
        scan_req = 1'b0; clear_start = 1'b0;
        #1;
        chk("clr_end_busy",  32'(clear_busy), 0);
        chk("clr_end_grant", 32'(wr_grant),   1);
        chk("clr_end_addr",  32'(mem_addr),   0);
        chk("clr_end_wdata", 32'(mem_wdata),  9);
        tick();
        wr_req = '0;

        // ---------------- reset aborts a clear ----------------
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("abort_addr", 32'(mem_addr), 32'(c));
            tick();
        end
        #1;
        chk("abort_cnt5", 32'(mem_addr), 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(clear_busy), 0);
        chk("abort_we",   32'(mem_we),     0);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        #1;
        chk("restart_busy", 32'(clear_busy), 1);
        chk("restart_addr", 32'(mem_addr),   0);
        chk("restart_we",   32'(mem_we),     1);
        for (int t = 0; t < 50 && clear_busy; t++) tick();
        chk("restart_done", 32'(clear_busy), 0);

        // ---------------- randomized traffic vs. model ----------------
        for (int a = 0; a < W*H; a++) exp_mem[a] = int'(COLOR_NONE);
        ptr_m     = 0;
        prev_scan = 1'b0;
        prev_exp  = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!wr_req[i] && ($urandom_range(0, 1) == 1)) begin
                    wr_req[i]   = 1'b1;
                    wr_x[i]     = XW'($urandom_range(0, 3));
                    wr_y[i]     = YW'($urandom_range(0, 3));
                    wr_color[i] = CW'($urandom);
                end
            end
            scan_req = ($urandom_range(0, 3) == 0);
            scan_x   = XW'($urandom_range(0, 3));
            scan_y   = YW'($urandom_range(0, 3));
            #1;
            chk("rnd_scan_valid", 32'(scan_valid), 32'(prev_scan));
            if (prev_scan) chk("rnd_scan_data", 32'(scan_data), 32'(prev_exp));

            exp_grant = '0;
            exp_we    = 1'b0;
            win       = -1;
            if (!scan_req) begin
                for (int k = 0; k < N; k++) begin
                    j = (ptr_m + k) % N;
                    if (win < 0 && wr_req[j]) win = j;
                end
                if (win >= 0) begin
                    exp_grant = 32'(1) << win;
                    ptr_m     = (win + 1) % N;
                    if (int'(wr_y[win]) < H && int'(wr_x[win]) < W) begin
                        exp_we = 1'b1;
                        exp_mem[int'(wr_y[win]) * W + int'(wr_x[win])] = int'(wr_color[win]);
                    end
                end
                prev_scan = 1'b0;
            end else begin
                prev_scan = 1'b1;
                if (int'(scan_y) < H && int'(scan_x) < W)
                    prev_exp = exp_mem[int'(scan_y) * W + int'(scan_x)];
                else
                    prev_exp = int'(COLOR_NONE);
            end
            chk("rnd_grant", 32'(wr_grant), exp_grant);
            chk("rnd_we",    32'(mem_we),   32'(exp_we));
            tick();
            if (win >= 0) wr_req[win] = 1'b0;
        end
        scan_req = 1'b0;
        wr_req   = '0;
        #1;
        chk("rnd_last_scan_valid", 32'(scan_valid), 32'(prev_scan));
        if (prev_scan) chk("rnd_last_scan_data", 32'(scan_data), 32'(prev_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
